// File: rtl/ddr2_controller_dmaster_pkg.sv
// Shared definitions for the dmaster packet-to-byte encoder: special byte
// values, the encoder sequencing enum, and the escape-decision helper.
// Latency: n/a (constants and a pure function). Backpressure: n/a.
package ddr2_controller_dmaster_pkg;

  localparam logic [7:0] SOP_CHAR     = 8'h7A;
  localparam logic [7:0] EOP_CHAR     = 8'h7B;
  localparam logic [7:0] CHANNEL_CHAR = 8'h7C;
  localparam logic [7:0] ESC_CHAR     = 8'h7D;
  localparam logic [7:0] ESC_XOR      = 8'h20;

  // Each state names the item that will be loaded into the output register
  // on the next advance; IDLE means the holding register is empty.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CH_MARK,
    ST_CH_ESC,
    ST_CH_VAL,
    ST_SOP,
    ST_EOP,
    ST_D_ESC,
    ST_DATA
  } enc_state_t;

  // Bytes in the marker range must be escaped wherever they appear as data.
  function automatic logic is_special(input logic [7:0] b);
    return (b >= 8'h7A) && (b <= 8'h7D);
  endfunction

endpackage

// File: rtl/ddr2_controller_dmaster_p2b_encoder.sv
// Serialises an Avalon-ST packet stream (data/SOP/EOP/channel) into an escaped
// byte stream. Latency: first byte valid 1 clk after the beat is accepted.
// Backpressure: output register holds while out_valid && !out_ready; in_ready
// is high when the holding register is empty or its DATA byte loads this cycle.
// Ports: clk/reset (async, active-high); in_* upstream beat with in_ready;
// out_valid/out_data registered encoded byte with out_ready.
module ddr2_controller_dmaster_p2b_encoder
  import ddr2_controller_dmaster_pkg::*;
#(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic [CHANNEL_WIDTH-1:0] in_channel,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data
);

  enc_state_t state;
  enc_state_t first_item;
  enc_state_t after_item;

  logic [7:0] h_data;
  logic [7:0] h_ch;
  logic       h_sop;
  logic       h_eop;
  logic [7:0] last_ch;
  logic       ch_known;

  logic [7:0] in_ch_byte;
  logic [7:0] item_byte;
  logic       advance;
  logic       accept;

  // Narrow channels are zero-extended into the channel byte.
  always_comb begin
    in_ch_byte = '0;
    in_ch_byte[CHANNEL_WIDTH-1:0] = in_channel;
  end

  assign advance  = !out_valid || out_ready;
  // Accepting while the DATA byte loads keeps a plain payload stream at 1 byte/clk.
  assign in_ready = (state == ST_IDLE) || (advance && (state == ST_DATA));
  assign accept   = in_valid && in_ready;

  // First item of an incoming beat. ch_known/last_ch are settled here: a beat
  // is only accepted once the previous beat's channel value has been sent.
  always_comb begin
    if (in_startofpacket && (!ch_known || (in_ch_byte != last_ch)))
      first_item = ST_CH_MARK;
    else if (in_startofpacket)
      first_item = ST_SOP;
    else if (in_endofpacket)
      first_item = ST_EOP;
    else if (is_special(in_data))
      first_item = ST_D_ESC;
    else
      first_item = ST_DATA;
  end

  // Byte for the current item and the next required item after it.
  always_comb begin
    item_byte  = h_data;
    after_item = ST_IDLE;
    case (state)
      ST_CH_MARK: begin
        item_byte  = CHANNEL_CHAR;
        after_item = is_special(h_ch) ? ST_CH_ESC : ST_CH_VAL;
      end
      ST_CH_ESC: begin
        item_byte  = ESC_CHAR;
        after_item = ST_CH_VAL;
      end
      ST_CH_VAL: begin
        item_byte  = is_special(h_ch) ? (h_ch ^ ESC_XOR) : h_ch;
        after_item = ST_SOP;  // a channel header only ever precedes an SOP
      end
      ST_SOP: begin
        item_byte  = SOP_CHAR;
        after_item = h_eop ? ST_EOP : (is_special(h_data) ? ST_D_ESC : ST_DATA);
      end
      ST_EOP: begin
        item_byte  = EOP_CHAR;
        after_item = is_special(h_data) ? ST_D_ESC : ST_DATA;
      end
      ST_D_ESC: begin
        item_byte  = ESC_CHAR;
        after_item = ST_DATA;
      end
      ST_DATA: begin
        item_byte  = is_special(h_data) ? (h_data ^ ESC_XOR) : h_data;
        after_item = ST_IDLE;
      end
      default: begin
        item_byte  = h_data;
        after_item = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      h_data    <= 8'h00;
      h_ch      <= 8'h00;
      h_sop     <= 1'b0;
      h_eop     <= 1'b0;
      last_ch   <= 8'h00;
      ch_known  <= 1'b0;
    end else begin
      if (advance) begin
        if (state != ST_IDLE) begin
          out_valid <= 1'b1;
          out_data  <= item_byte;
          state     <= after_item;
          if (state == ST_CH_VAL) begin
            last_ch  <= h_ch;
            ch_known <= 1'b1;
          end
        end else begin
          out_valid <= 1'b0;
        end
      end
      // A beat accepted alongside the DATA byte overrides the return to IDLE.
      if (accept) begin
        h_data <= in_data;
        h_ch   <= in_ch_byte;
        h_sop  <= in_startofpacket;
        h_eop  <= in_endofpacket;
        state  <= first_item;
      end
    end
  end

endmodule

// File: tb/tb_ddr2_controller_dmaster_p2b_encoder.sv
module tb_ddr2_controller_dmaster_p2b_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_sop = 1'b0;
  logic       in_eop = 1'b0;
  logic [7:0] in_channel = 8'h00;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_beats = 0;
  bit bp_mode = 1'b0;
  logic [7:0] q[$];
  int qcyc[$];
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  ddr2_controller_dmaster_p2b_encoder #(.CHANNEL_WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .in_ready(in_ready),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_startofpacket(in_sop),
    .in_endofpacket(in_eop),
    .in_channel(in_channel),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (bp_mode) out_ready = ~out_ready;
    else out_ready = 1'b1;
  end

  // Collects output transfers and accepted beats; checks stall stability.
  always @(negedge clk) begin
    if (prev_stall && !reset) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== prev_data) begin
        bad++;
        $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h",
                 out_valid, out_data, prev_data);
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (out_valid && out_ready) begin
      q.push_back(out_data);
      qcyc.push_back(cyc);
    end
    if (in_valid && in_ready) acc_beats++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [7:0] d, input logic s, input logic e, input logic [7:0] ch);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    in_sop = s;
    in_eop = e;
    in_channel = ch;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL beat_accept: data=%h not accepted within 200 cycles", d);
    end
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
  endtask

  task automatic clear_q();
    q.delete();
    qcyc.delete();
    acc_beats = 0;
  endtask

  task automatic wait_bytes(input int n);
    int k;
    k = 0;
    while (q.size() < n && k < 300) begin
      @(posedge clk);
      #2;
      k++;
    end
    repeat (5) @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_out: valid=%b data=%h, required valid=0 data=00", out_valid, out_data);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b valid=%b, required in_ready=1 valid=0", in_ready, out_valid);
    end
  endtask

  task automatic test_packet1();
    logic [7:0] exp[8] = '{8'h7C, 8'h00, 8'h7A, 8'h11, 8'h7D, 8'h5A, 8'h7B, 8'h22};
    clear_q();
    drive(8'h11, 1'b1, 1'b0, 8'h00);
    drive(8'h7A, 1'b0, 1'b0, 8'h00);
    drive(8'h22, 1'b0, 1'b1, 8'h00);
    idle_in();
    wait_bytes(8);
    total++;
    if (q.size() != 8) begin
      bad++;
      $display("FAIL pkt1_len: got %0d bytes, required 8", q.size());
    end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      total++;
      if (q[i] !== exp[i]) begin
        bad++;
        $display("FAIL pkt1_byte%0d: got %h, required %h", i, q[i], exp[i]);
      end
    end
    total++;
    if (acc_beats != 3) begin
      bad++;
      $display("FAIL pkt1_beats: accepted %0d, required 3", acc_beats);
    end
  endtask

  task automatic test_same_channel();
    logic [7:0] exp[3] = '{8'h7A, 8'h7B, 8'h33};
    clear_q();
    drive(8'h33, 1'b1, 1'b1, 8'h00);
    idle_in();
    wait_bytes(3);
    total++;
    if (q.size() != 3) begin
      bad++;
      $display("FAIL same_ch_len: got %0d bytes, required 3", q.size());
    end
    for (int i = 0; i < 3 && i < q.size(); i++) begin
      total++;
      if (q[i] !== exp[i]) begin
        bad++;
        $display("FAIL same_ch_byte%0d: got %h, required %h", i, q[i], exp[i]);
      end
    end
  endtask

  task automatic test_special_channel();
    logic [7:0] exp[7] = '{8'h7C, 8'h7D, 8'h5D, 8'h7A, 8'h7B, 8'h7D, 8'h5C};
    clear_q();
    drive(8'h7C, 1'b1, 1'b1, 8'h7D);
    idle_in();
    wait_bytes(7);
    total++;
    if (q.size() != 7) begin
      bad++;
      $display("FAIL spec_ch_len: got %0d bytes, required 7", q.size());
    end
    for (int i = 0; i < 7 && i < q.size(); i++) begin
      total++;
      if (q[i] !== exp[i]) begin
        bad++;
        $display("FAIL spec_ch_byte%0d: got %h, required %h", i, q[i], exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[8] = '{8'h7C, 8'h00, 8'h7A, 8'h11, 8'h7D, 8'h5A, 8'h7B, 8'h22};
    clear_q();
    bp_mode = 1'b1;
    drive(8'h11, 1'b1, 1'b0, 8'h00);
    drive(8'h7A, 1'b0, 1'b0, 8'h00);
    drive(8'h22, 1'b0, 1'b1, 8'h00);
    idle_in();
    wait_bytes(8);
    bp_mode = 1'b0;
    @(posedge clk);
    #2;
    total++;
    if (q.size() != 8) begin
      bad++;
      $display("FAIL bp_len: got %0d bytes, required 8", q.size());
    end
    for (int i = 0; i < 8 && i < q.size(); i++) begin
      total++;
      if (q[i] !== exp[i]) begin
        bad++;
        $display("FAIL bp_byte%0d: got %h, required %h", i, q[i], exp[i]);
      end
    end
    total++;
    if (acc_beats != 3) begin
      bad++;
      $display("FAIL bp_beats: accepted %0d, required 3", acc_beats);
    end
  endtask

  task automatic test_streaming();
    logic [7:0] d;
    clear_q();
    for (int i = 0; i < 16; i++) begin
      d = 8'h40 + 8'(i);
      drive(d, 1'b0, 1'b0, 8'h00);
    end
    idle_in();
    wait_bytes(16);
    total++;
    if (q.size() != 16) begin
      bad++;
      $display("FAIL stream_len: got %0d bytes, required 16", q.size());
    end
    for (int i = 0; i < 16 && i < q.size(); i++) begin
      d = 8'h40 + 8'(i);
      total++;
      if (q[i] !== d || (qcyc[i] - qcyc[0]) != i) begin
        bad++;
        $display("FAIL stream_byte%0d: got %h at +%0d clk, required %h at +%0d clk",
                 i, q[i], qcyc[i] - qcyc[0], d, i);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp[4] = '{8'h7C, 8'h05, 8'h7A, 8'h01};
    int k;
    clear_q();
    drive(8'h01, 1'b1, 1'b0, 8'h05);
    idle_in();
    k = 0;
    while (q.size() < 1 && k < 50) begin
      @(posedge clk);
      #2;
      k++;
    end
    total++;
    if (q.size() < 1 || q[0] !== 8'h7C) begin
      bad++;
      $display("FAIL mid_first: got %0d bytes (first %h), required first byte 7C",
               q.size(), (q.size() > 0) ? q[0] : 8'hxx);
    end
    #3;
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_async_reset: out_valid=%b, required 0", out_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    clear_q();
    drive(8'h01, 1'b1, 1'b0, 8'h05);
    idle_in();
    wait_bytes(4);
    total++;
    if (q.size() != 4) begin
      bad++;
      $display("FAIL mid_len: got %0d bytes, required 4", q.size());
    end
    for (int i = 0; i < 4 && i < q.size(); i++) begin
      total++;
      if (q[i] !== exp[i]) begin
        bad++;
        $display("FAIL mid_byte%0d: got %h, required %h", i, q[i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_packet1();
    test_same_channel();
    test_special_channel();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
